sd_channel_arbiter: RTL
=======================

# sd_channel_arbiter

Parametrised N-channel front end for the single SD_Card reader: arbitrates client requests round-robin, multiplexes the granted client's block address and read strobe onto the card, and demultiplexes the returned sector bytes, completion and errors back to that client only. It sits between the audio/file clients and one SD_Card instance and replaces the fixed six-way, fixed-priority mutex-plus-OR-mux front end. It adds fair arbitration, read edge qualification, per-client completion pulses, sticky per-client error flags and grant hold across an in-flight read.

## Interface
- N, 6: number of client channels (2..16).
- BLOCK_W, 32: block address width.
- BUF_AW, 9: client buffer address width (512-byte sector).
- Clk  in  1  system clock; all logic on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Request  in  N  per-client bus request, level.
- Grant  out  N  one-hot (or zero) grant, registered.
- Block  in  N*BLOCK_W  client block addresses, channel i at [i*BLOCK_W +: BLOCK_W].
- Read  in  N  per-client read request, level; qualified as described below.
- Busy  out  N  Busy[i] high while channel i has a read in flight.
- Done  out  N  one-cycle pulse on read completion for channel i.
- Error  out  N  sticky card error attributed to channel i; cleared only by Reset.
- Address  out  BUF_AW  buffer address, passed through from Card_Address.
- Data  out  8  buffer data, passed through from Card_Data.
- Write_Enable  out  N  Card_Write_Enable routed to the granted channel only.
- Card_Block  out  BLOCK_W  registered block address to SD_Card.
- Card_Read  out  1  one-cycle read strobe to SD_Card.
- Card_Busy  in  1  SD_Card busy.
- Card_Address, Card_Data, Card_Write_Enable, Card_Error  in  BUF_AW/8/1/1  SD_Card outputs.

## Operation
- State machine states: IDLE, GRANTED, ISSUE, WAIT_START, WAIT_END.
- IDLE: if any Request, grant the first requester found scanning upward from Pointer+1, wrapping modulo N. Register Grant, store the index in G, move to GRANTED. The reset value of Pointer is N-1, so index 0 wins first.
- GRANTED:
  - If Request[G]=0: clear Grant, set Pointer=G, go to IDLE.
  - Else, if Read[G]=1, Armed=1 and Card_Busy=0: latch Block[G] into Card_Block, clear Armed, go to ISSUE.
  - Armed is set on entry to GRANTED from IDLE and whenever Read[G]=0 is sampled. A Read held high therefore issues exactly one read per grant, or per low-to-high transition.
- ISSUE: Card_Read=1 for this cycle only; go to WAIT_START.
- WAIT_START: wait for Card_Busy=1, then go to WAIT_END.
- WAIT_END: wait for Card_Busy=0, then pulse Done[G] and return to GRANTED.
- Busy[G]=1 in ISSUE, WAIT_START and WAIT_END.
- Grant is held through ISSUE..WAIT_END even if Request[G] drops. Reads cannot be aborted. The release is evaluated in GRANTED on the cycle after Done.
- Write_Enable[i] = Card_Write_Enable & Grant[i], combinational. Address and Data are unconditional pass-through.
- Card_Error=1 in any state with a grant held sets Error[G]. Card_Error with no grant is ignored.
- Read[i] and Block[i] of ungranted channels are ignored.

## Timing
- Reset values:
  - Grant=0, Busy=0, Done=0, Error=0, Card_Read=0, Card_Block=0.
  - State=IDLE, Pointer=N-1, Armed=0.
- Reset mid-read returns to IDLE immediately. SD_Card shares the same Reset.
- Request high at cycle t in IDLE -> Grant at t+1.
- Release: Request low at t in GRANTED -> Grant=0 at t+1. The next grant is at t+2 at the earliest (one idle cycle guaranteed).
- Read high at t in GRANTED -> Card_Read high during t+1. Card_Block is valid from t+1 and held until the next issue.
- Card_Busy falling at t -> Done[G] high during t+1.
- Earliest next issue is at t+2 (Read low for one sampled cycle, then high).

## Test plan
- Reset, then Request=6'b000001 -> Grant=000001 one cycle later. Read pulse with Block[0]=0x0000_1234 -> Card_Read one cycle, Card_Block=0x1234. Card_Busy high for 520 cycles -> one Done[0] pulse, Busy[0] high throughout.
- Requests 000111 held, each client releasing after one read -> grant order 0,1,2, then 0 again. Exactly one idle cycle between grants.
- Client 3 drops Request during WAIT_END -> Grant[3] stays until Done[3], then clears on the next cycle.
- Read[1] held high for 3 full reads' duration -> exactly one Card_Read. Dropping Read for one cycle and raising it again -> a second read.
- Card_Error pulse during client 4's read -> Error=010000 persists across later grants. Only Reset clears it.
- Card_Write_Enable bursts during client 2's read -> only Write_Enable[2] toggles. Reset asserted mid-burst -> all outputs 0 on the next cycle.

Source files
------------

// File: rtl/sd_channel_arbiter_if.sv
// Client-side bus of the SD card channel arbiter: per-channel request/grant,
// read handshake, status flags and the shared sector buffer write port.
interface sd_channel_arbiter_if #(
   parameter int N       = 6,
   parameter int BLOCK_W = 32,
   parameter int BUF_AW  = 9
);
   logic [N-1:0]         request;
   logic [N-1:0]         grant;
   logic [N*BLOCK_W-1:0] block;
   logic [N-1:0]         read;
   logic [N-1:0]         busy;
   logic [N-1:0]         done;
   logic [N-1:0]         error;
   logic [BUF_AW-1:0]    address;
   logic [7:0]           data;
   logic [N-1:0]         write_enable;

   modport master (
      output request, block, read,
      input  grant, busy, done, error, address, data, write_enable
   );

   modport slave (
      input  request, block, read,
      output grant, busy, done, error, address, data, write_enable
   );
endinterface

// File: rtl/sd_channel_arbiter.sv
// Round-robin N-channel front end for one SD card reader: grants one client,
// issues its reads and routes completion, errors and buffer writes back to it.
//
// state      | meaning
// IDLE       | no grant; pick next requester after ptr
// GRANTED    | grant held; release or issue a read
// ISSUE      | card_read strobe for one cycle
// WAIT_START | waiting for the card to raise busy
// WAIT_END   | waiting for the card to drop busy
module sd_channel_arbiter #(
   parameter int N       = 6,
   parameter int BLOCK_W = 32,
   parameter int BUF_AW  = 9
) (
   input  logic               clk,
   input  logic               reset,
   sd_channel_arbiter_if.slave bus,
   output logic [BLOCK_W-1:0] card_block,
   output logic               card_read,
   input  logic               card_busy,
   input  logic [BUF_AW-1:0]  card_address,
   input  logic [7:0]         card_data,
   input  logic               card_write_enable,
   input  logic               card_error
);
   localparam int IW = (N > 1) ? $clog2(N) : 1;

   localparam logic [2:0] S_IDLE       = 3'd0;
   localparam logic [2:0] S_GRANTED    = 3'd1;
   localparam logic [2:0] S_ISSUE      = 3'd2;
   localparam logic [2:0] S_WAIT_START = 3'd3;
   localparam logic [2:0] S_WAIT_END   = 3'd4;

   logic [2:0]    state;
   logic [IW-1:0] ptr;
   logic [IW-1:0] g;
   logic          armed;
   logic [N-1:0]  grant_q;
   logic [N-1:0]  busy_q;
   logic [N-1:0]  done_q;
   logic [N-1:0]  error_q;

   logic          found;
   logic [IW-1:0] pick;
   int unsigned   idx;

   // Scan upward from ptr+1 so the last released channel has lowest priority.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      idx   = 0;
      for (int k = 1; k <= N; k++) begin
         idx = (int'(ptr) + k) % N;
         if (!found && bus.request[idx]) begin
            found = 1'b1;
            pick  = IW'(idx);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         ptr        <= IW'(N - 1);
         g          <= '0;
         armed      <= 1'b0;
         grant_q    <= '0;
         busy_q     <= '0;
         done_q     <= '0;
         error_q    <= '0;
         card_read  <= 1'b0;
         card_block <= '0;
      end else begin
         done_q    <= '0;
         card_read <= 1'b0;
         if (|grant_q && card_error) error_q[g] <= 1'b1;
         // A low Read re-arms so a held-high Read issues only once.
         if (|grant_q && !bus.read[g]) armed <= 1'b1;
         case (state)
            S_IDLE: begin
               if (found) begin
                  grant_q <= {{(N-1){1'b0}}, 1'b1} << pick;
                  g       <= pick;
                  armed   <= 1'b1;
                  state   <= S_GRANTED;
               end
            end
            S_GRANTED: begin
               if (!bus.request[g]) begin
                  grant_q <= '0;
                  ptr     <= g;
                  state   <= S_IDLE;
               end else if (bus.read[g] && armed && !card_busy) begin
                  card_block <= bus.block[g*BLOCK_W +: BLOCK_W];
                  armed      <= 1'b0;
                  card_read  <= 1'b1;
                  busy_q[g]  <= 1'b1;
                  state      <= S_ISSUE;
               end
            end
            S_ISSUE: state <= S_WAIT_START;
            S_WAIT_START: begin
               if (card_busy) state <= S_WAIT_END;
            end
            S_WAIT_END: begin
               if (!card_busy) begin
                  done_q[g] <= 1'b1;
                  busy_q    <= '0;
                  state     <= S_GRANTED;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.grant        = grant_q;
   assign bus.busy         = busy_q;
   assign bus.done         = done_q;
   assign bus.error        = error_q;
   assign bus.address      = card_address;
   assign bus.data         = card_data;
   assign bus.write_enable = {N{card_write_enable}} & grant_q;
endmodule
